// File: rtl/fan_cfg_loader.sv
// Byte-wide configuration loader for the fan controller: keeps a shadow register
// set and copies a committed set into the active outputs on a controller sample tick.
module fan_cfg_loader #(
  parameter int COEF_BITWIDTH      = 8,
  parameter int ADC_BITWIDTH       = 4,
  parameter int TIMEOUT_CYCLES     = 1000000,
  parameter int B2_DEFAULT         = 94,
  parameter int B1_DEFAULT         = -93,
  parameter int B0_DEFAULT         = 0,
  parameter int A1_DEFAULT         = -64,
  parameter int A0_DEFAULT         = 0,
  parameter int PWM_PERIOD_DEFAULT = 18,
  parameter int PWM_MIN_DEFAULT    = 3
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [7:0]               data_i,
  input  logic                     strobe_i,
  input  logic                     pid_tick_i,
  output logic [COEF_BITWIDTH-1:0] b2_o,
  output logic [COEF_BITWIDTH-1:0] b1_o,
  output logic [COEF_BITWIDTH-1:0] b0_o,
  output logic [COEF_BITWIDTH-1:0] a1_o,
  output logic [COEF_BITWIDTH-1:0] a0_o,
  output logic [ADC_BITWIDTH:0]    pwm_period_o,
  output logic [ADC_BITWIDTH-1:0]  pwm_min_o,
  output logic                     pending_o,
  output logic                     error_o
);
  localparam int CW    = COEF_BITWIDTH;
  localparam int PW    = ADC_BITWIDTH + 1;
  localparam int MW    = ADC_BITWIDTH;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_COMMIT   = 4'h2;
  localparam logic [3:0] OP_DISCARD  = 4'h3;
  localparam logic [3:0] OP_DEFAULTS = 4'h4;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_DATA = 1'b1} state_t;

  typedef struct packed {
    logic [CW-1:0] b2;
    logic [CW-1:0] b1;
    logic [CW-1:0] b0;
    logic [CW-1:0] a1;
    logic [CW-1:0] a0;
    logic [PW-1:0] period;
    logic [MW-1:0] pmin;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = {CW'(B2_DEFAULT), CW'(B1_DEFAULT), CW'(B0_DEFAULT),
                                  CW'(A1_DEFAULT), CW'(A0_DEFAULT),
                                  PW'(PWM_PERIOD_DEFAULT), MW'(PWM_MIN_DEFAULT)};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       addr_r, addr_s;
  cfg_t             shadow_r, shadow_s;
  cfg_t             active_r, active_s;
  logic             pending_r, pending_s;
  logic             error_r, error_s;
  logic             s1_r, s2_r, s3_r;
  logic             accept_s;

  function automatic cfg_t write_field(input cfg_t cfg, input logic [2:0] addr,
                                       input logic [7:0] val);
    cfg_t res;
    res = cfg;
    case (addr)
      3'd0:    res.b2     = CW'(val);
      3'd1:    res.b1     = CW'(val);
      3'd2:    res.b0     = CW'(val);
      3'd3:    res.a1     = CW'(val);
      3'd4:    res.a0     = CW'(val);
      3'd5:    res.period = val[PW-1:0];
      3'd6:    res.pmin   = val[MW-1:0];
      default: res        = cfg;
    endcase
    return res;
  endfunction

  // strobe synchronizer and rising-edge detect register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= strobe_i;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign accept_s = s2_r & ~s3_r;

  // command decode, timeout and apply; the commit path overrides the apply's pending clear
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    shadow_s  = shadow_r;
    active_s  = active_r;
    pending_s = pending_r;
    error_s   = error_r;
    if (pid_tick_i && pending_r) begin
      active_s  = shadow_r;
      pending_s = 1'b0;
    end else begin
      active_s  = active_r;
    end
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (data_i[7:4])
            OP_WRITE: begin
              if (data_i[3:0] <= 4'd6) begin
                addr_s  = data_i[2:0];
                cnt_s   = '0;
                state_s = WAIT_DATA;
              end else begin
                error_s = 1'b1;
              end
            end
            OP_COMMIT: begin
              if (shadow_r.period > {1'b0, shadow_r.pmin}) begin
                pending_s = 1'b1;
              end else begin
                error_s = 1'b1;
              end
            end
            OP_DISCARD: begin
              shadow_s  = active_r;
              pending_s = 1'b0;
              error_s   = 1'b0;
            end
            OP_DEFAULTS: shadow_s = CFG_DEFAULT;
            default:     error_s  = 1'b1;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_DATA: begin
        if (accept_s) begin
          shadow_s = write_field(shadow_r, addr_r, data_i);
          state_s  = IDLE;
        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          error_s = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // state, shadow and active register set
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      addr_r    <= 3'd0;
      shadow_r  <= CFG_DEFAULT;
      active_r  <= CFG_DEFAULT;
      pending_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      shadow_r  <= shadow_s;
      active_r  <= active_s;
      pending_r <= pending_s;
      error_r   <= error_s;
    end
  end

  assign b2_o         = active_r.b2;
  assign b1_o         = active_r.b1;
  assign b0_o         = active_r.b0;
  assign a1_o         = active_r.a1;
  assign a0_o         = active_r.a0;
  assign pwm_period_o = active_r.period;
  assign pwm_min_o    = active_r.pmin;
  assign pending_o    = pending_r;
  assign error_o      = error_r;

endmodule

// File: tb/tb_fan_cfg_loader.sv
// Bench for fan_cfg_loader: directed scenarios plus random byte streams, compared
// every cycle against an event-level model of the register set.
module tb_fan_cfg_loader;
  localparam int T = 40;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       strobe_i = 1'b0;
  logic       pid_tick_i = 1'b0;
  logic [7:0] b2_o, b1_o, b0_o, a1_o, a0_o;
  logic [4:0] pwm_period_o;
  logic [3:0] pwm_min_o;
  logic       pending_o, error_o;

  always #5 clk_i = ~clk_i;

  fan_cfg_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i), .strobe_i(strobe_i),
    .pid_tick_i(pid_tick_i), .b2_o(b2_o), .b1_o(b1_o), .b0_o(b0_o), .a1_o(a1_o),
    .a0_o(a0_o), .pwm_period_o(pwm_period_o), .pwm_min_o(pwm_min_o),
    .pending_o(pending_o), .error_o(error_o)
  );

  int checks = 0;
  int errors = 0;
  bit rand_ticks = 1'b0;

  // model: register set indexed by address, plus protocol state as plain variables
  int unsigned sh[7], ac[7];
  bit pend_m, err_m, wait_m, model_ok;
  int waddr_m, hdr_edge, edge_n;
  bit st1, st2, st3;

  function automatic int unsigned dflt(int i);
    case (i)
      0: return 94;
      1: return 32'hA3;
      2: return 0;
      3: return 32'hC0;
      4: return 0;
      5: return 18;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned fit(int a, int unsigned v);
    if (a == 5) return v % 32;
    if (a == 6) return v % 16;
    return v % 256;
  endfunction

  // a byte takes effect two edges after the edge that first samples strobe high
  always @(posedge clk_i) begin : model
    int unsigned osh[7];
    int unsigned oac[7];
    bit acc;
    edge_n++;
    if (!rstn_i) begin
      for (int i = 0; i < 7; i++) begin sh[i] = dflt(i); ac[i] = dflt(i); end
      pend_m = 0; err_m = 0; wait_m = 0; st1 = 0; st2 = 0; st3 = 0; model_ok = 1;
    end else begin
      osh = sh; oac = ac;
      acc = st2 && !st3;
      st3 = st2; st2 = st1; st1 = strobe_i;
      if (pid_tick_i && pend_m) begin ac = osh; pend_m = 0; end
      if (acc && wait_m) begin
        sh[waddr_m] = fit(waddr_m, data_i);
        wait_m = 0;
      end else if (acc) begin
        case (data_i[7:4])
          4'h1: if (data_i[3:0] < 7) begin
                  wait_m = 1; waddr_m = int'(data_i[3:0]); hdr_edge = edge_n;
                end else err_m = 1;
          4'h2: if (osh[5] > osh[6]) pend_m = 1; else err_m = 1;
          4'h3: begin sh = oac; pend_m = 0; err_m = 0; end
          4'h4: for (int i = 0; i < 7; i++) sh[i] = dflt(i);
          default: err_m = 1;
        endcase
      end else if (wait_m && (edge_n - hdr_edge == T)) begin
        err_m = 1; wait_m = 0;
      end
    end
  end

  task automatic lit(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_tick();
    pid_tick_i = rand_ticks && ($urandom_range(0, 5) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i); data_i = b; strobe_i = 1'b1; drive_tick();
    repeat (3) begin @(negedge clk_i); drive_tick(); end
    @(negedge clk_i); strobe_i = 1'b0; drive_tick();
    repeat (3) begin @(negedge clk_i); drive_tick(); end
    @(negedge clk_i); pid_tick_i = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_i); pid_tick_i = 1'b1;
    @(negedge clk_i); pid_tick_i = 1'b0;
  endtask

  initial begin
    logic [50:0] exp_v, act_v;
    fork
      forever begin
        @(negedge clk_i);
        if (model_ok) begin
          exp_v = {8'(ac[0]), 8'(ac[1]), 8'(ac[2]), 8'(ac[3]), 8'(ac[4]),
                   5'(ac[5]), 4'(ac[6]), pend_m, err_m};
          act_v = {b2_o, b1_o, b0_o, a1_o, a0_o, pwm_period_o, pwm_min_o,
                   pending_o, error_o};
          checks++;
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs got %h want %h at %0t", act_v, exp_v, $time);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    lit("rst_b2", b2_o, 94); lit("rst_b1", b1_o, 8'hA3); lit("rst_a1", a1_o, 8'hC0);
    lit("rst_per", pwm_period_o, 18); lit("rst_min", pwm_min_o, 3);
    lit("rst_pend", pending_o, 0); lit("rst_err", error_o, 0);

    send_byte(8'h11); send_byte(8'h55); send_byte(8'h20);
    lit("commit_pend", pending_o, 1); lit("commit_hold_b1", b1_o, 8'hA3);
    tick();
    lit("apply_b1", b1_o, 8'h55); lit("apply_pend", pending_o, 0);

    send_byte(8'h15); send_byte(8'h02); send_byte(8'h16); send_byte(8'h0F);
    send_byte(8'h20);
    lit("bad_commit_err", error_o, 1); lit("bad_commit_pend", pending_o, 0);
    lit("bad_commit_per", pwm_period_o, 18);
    send_byte(8'h30);
    lit("discard_err", error_o, 0);
    send_byte(8'h20);
    lit("reload_pend", pending_o, 1);
    tick();
    lit("reload_per", pwm_period_o, 18); lit("reload_min", pwm_min_o, 3);

    send_byte(8'h17); lit("bad_addr_err", error_o, 1); send_byte(8'h30);
    send_byte(8'h50); lit("bad_op_err", error_o, 1); send_byte(8'h30);
    send_byte(8'h11); repeat (T + 5) @(negedge clk_i);
    lit("timeout_err", error_o, 1); send_byte(8'h30);
    send_byte(8'h12); send_byte(8'h07); send_byte(8'h20); tick();
    lit("after_to_b0", b0_o, 8'h07);

    send_byte(8'h13); send_byte(8'h10);
    @(negedge clk_i); data_i = 8'h20; strobe_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i); pid_tick_i = 1'b1;
    @(negedge clk_i); pid_tick_i = 1'b0;
    lit("same_tick_pend", pending_o, 1); lit("same_tick_a1", a1_o, 8'hC0);
    @(negedge clk_i); strobe_i = 1'b0; repeat (4) @(negedge clk_i);
    tick();
    lit("next_tick_a1", a1_o, 8'h10); lit("next_tick_pend", pending_o, 0);

    send_byte(8'h14); send_byte(8'h22); send_byte(8'h20);
    lit("pre_rst_pend", pending_o, 1);
    send_byte(8'h11);
    @(negedge clk_i); rstn_i = 1'b0;
    @(negedge clk_i); rstn_i = 1'b1;
    lit("mid_rst_b1", b1_o, 8'hA3); lit("mid_rst_a0", a0_o, 0);
    lit("mid_rst_pend", pending_o, 0);
    send_byte(8'h20);
    lit("post_rst_hdr", pending_o, 1);
    tick();

    rand_ticks = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 7))
        0, 1, 2: op = 4'h1;
        3:       op = 4'h2;
        4:       op = 4'h3;
        5:       op = 4'h4;
        default: op = 4'($urandom_range(0, 15));
      endcase
      send_byte({op, 4'($urandom_range(0, 8))});
      if (op == 4'h1 && $urandom_range(0, 9) != 0) send_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 39) == 0) repeat (T + 3) @(negedge clk_i);
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk_i); rstn_i = 1'b0; @(negedge clk_i); rstn_i = 1'b1;
      end
    end
    rand_ticks = 1'b0;
    repeat (4) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_cfg_loader.md
# fan_cfg_loader

Runtime configuration sequencer for the fan controller datapath. It receives byte-wide commands from the bidirectional pins and keeps a shadow copy of the PI coefficients (b2, b1, b0, a1, a0), the PWM period and the minimum fan speed. A committed set is copied into the active outputs atomically, on a controller sample boundary, so the controller never runs a sample with a mixed coefficient set. It sits between the top-level pins and the FanCTRL parameter inputs; its reset values equal the current hard-wired constants.

## Interface
- COEF_BITWIDTH, 8, width of each coefficient (signed, 6 fractional bits)
- ADC_BITWIDTH, 4, width of the ADC, SET and min-speed values; the PWM period is ADC_BITWIDTH+1 bits
- TIMEOUT_CYCLES, 1000000, maximum number of cycles allowed between a WRITE header and its data byte
- B2_DEFAULT 94, B1_DEFAULT -93, B0_DEFAULT 0, A1_DEFAULT -64, A0_DEFAULT 0, PWM_PERIOD_DEFAULT 18, PWM_MIN_DEFAULT 3: reset values of the register set
- clk_i  in  1  system clock (1 MHz); one clock domain
- rstn_i  in  1  reset; synchronous and active-low
- data_i  in  8  command/data byte; must be stable from before strobe_i rises until after strobe_i falls
- strobe_i  in  1  asynchronous byte strobe; each rising edge delivers one byte
- pid_tick_i  in  1  single-cycle pulse from the controller marking the sample boundary
- b2_o, b1_o, b0_o, a1_o, a0_o  out  COEF_BITWIDTH each  active coefficients
- pwm_period_o  out  ADC_BITWIDTH+1  active PWM period counter value
- pwm_min_o  out  ADC_BITWIDTH  active minimum fan speed
- pending_o  out  1  a commit is waiting for the next pid_tick_i
- error_o  out  1  sticky protocol error flag

## Operation
- Input synchronizer: strobe_i passes through 2 flops (s1, s2) plus an edge register s3. accept = s2 & ~s3. data_i is sampled in the accept cycle.
- Command byte: [7:4] = opcode, [3:0] = address.
- Opcode 0x1 WRITE, 0x2 COMMIT, 0x3 DISCARD, 0x4 DEFAULTS. Any other opcode sets error_o; FSM stays in IDLE.
- Address map: 0 b2, 1 b1, 2 b0, 3 a1, 4 a0, 5 pwm_period (low 5 bits used), 6 pwm_min (low 4 bits used).
- The address field is checked only for WRITE. Address 7..15 sets error_o and the data byte is not awaited.
- FSM IDLE: on accept, decode the command byte.
  - WRITE with a valid address: latch the address, clear the timeout counter, go to WAIT_DATA.
  - COMMIT: if shadow pwm_period > shadow pwm_min, set pending. Otherwise set error_o and leave pending unchanged.
  - DISCARD: shadow := active, pending := 0, error_o := 0.
  - DEFAULTS: shadow := default parameters; active and pending are unchanged.
- FSM WAIT_DATA:
  - On accept: shadow[addr] := byte, go to IDLE.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no accept: set error_o, discard the header, go to IDLE.
- Apply: on pid_tick_i with pending = 1, all active registers := shadow in that same edge, and pending := 0.
  - The values copied are the shadow values registered before that edge. A shadow write in the same cycle is not copied; it waits for the next commit.
- WRITE while pending = 1 is allowed; it modifies the shadow that will be applied.
- COMMIT accepted in the same cycle as pid_tick_i: pending is set, and the apply happens at the following pid_tick_i.
- pid_tick_i with pending = 0: no effect.
- error_o is cleared only by DISCARD or by reset.
- Reset (rstn_i = 0 at an edge, including mid-frame or while pending):
  - shadow and active := defaults
  - pending_o = 0, error_o = 0
  - FSM = IDLE, timeout counter = 0, s1/s2/s3 = 0
  - b2_o = 94, b1_o = -93 (0xA3), b0_o = 0, a1_o = -64 (0xC0), a0_o = 0, pwm_period_o = 18, pwm_min_o = 3

## Timing
- strobe_i rises before edge E0: s1 = 1 after E0, s2 = 1 after E1, accept is high between E1 and E2, and the command takes effect at E2.
- Minimum strobe high time and low time: 3 clk_i cycles each.
- pending_o rises at the edge that accepts COMMIT.
- Active outputs change at the edge that samples pid_tick_i = 1; pending_o falls at that same edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset -> b2_o = 94, b1_o = 0xA3, a1_o = 0xC0, pwm_period_o = 18, pwm_min_o = 3, pending_o = 0, error_o = 0.
- Send 0x11, 0x55, then 0x20 -> pending_o = 1 and b1_o stays 0xA3 until pid_tick_i, then b1_o = 0x55 and pending_o = 0 at that edge.
- Send 0x16, 0x0F (min 15 ≥ period 18? no: set 0x15, 0x02 first), then 0x20 -> error_o = 1, pending_o stays 0, outputs unchanged. Then send 0x30 -> error_o = 0 and shadow reloaded from active.
- Send 0x17, 0x50, and 0x11 followed by no data for TIMEOUT_CYCLES -> error_o = 1 each time, FSM back in IDLE, and the next valid WRITE/COMMIT still works.
- COMMIT accepted in the same cycle as pid_tick_i -> no apply at that tick; apply at the next tick.
- Assert rstn_i low in WAIT_DATA with pending = 1 -> all outputs at default values, pending_o = 0, and the next byte is decoded as a header.
